data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter: len_data, default 32, data word width in bits.
REQ-002 Parameter: ram_depth, default 64, number of memory words; AW = ceil(log2(ram_depth)), which is 6 by default.
REQ-003 Ports:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- ctrl_clk_mips  in  1  MIPS step enable; 1 means the pipeline is advancing.
- mips_Addr / mips_In_Data / mips_Wr / mips_Rd  in  AW / len_data / 1 / 1  MEM-stage memory request.
- dump_start  in  1  debug unit request to dump all of memory; a pulse.
- dump_ready  in  1  debug unit can accept a word.
- mem_Data  in  len_data  combinational read data from the memory debug read port.
- Addr / In_Data / Wr / Rd  out  AW / len_data / 1 / 1  muxed memory port.
- dump_data / dump_addr / dump_valid  out  len_data / AW / 1  dump word stream.
- dump_busy  out  1  dump in progress; also the MIPS halt request.
- dump_done  out  1  one-cycle pulse at dump end.
- arb_err  out  1  sticky protocol error flag.

Function
REQ-004 The arbiter SHALL implement the FSM states IDLE, WAIT_HALT, READ, HOLD and DONE.
REQ-005 In IDLE the arbiter SHALL pass the memory port through combinationally: Addr=mips_Addr, In_Data=mips_In_Data, Wr=mips_Wr, Rd=mips_Rd.
REQ-006 In any state other than IDLE the arbiter SHALL drive Addr=address counter, Wr=0, Rd=0 and In_Data=0.
REQ-007 IDLE and dump_start=1 SHALL transition to WAIT_HALT, clear the counter to 0 and set dump_busy=1.
REQ-008 WAIT_HALT SHALL remain in WAIT_HALT while ctrl_clk_mips=1 and SHALL transition to READ on the first cycle with ctrl_clk_mips=0.
REQ-009 READ SHALL register mem_Data into dump_data and the counter into dump_addr, set dump_valid=1, and transition to HOLD in 1 cycle.
REQ-010 HOLD SHALL hold dump_data, dump_addr and dump_valid stable until dump_valid and dump_ready are both 1 in the same cycle.
REQ-011 On that handshake, dump_valid SHALL clear on the next edge, and:
- if counter = ram_depth-1, the FSM SHALL go to DONE;
- otherwise counter+1 and the FSM SHALL go to READ.
REQ-012 Throughput SHALL be a minimum of 2 cycles per word, for exactly ram_depth words at addresses 0..ram_depth-1 in ascending order with no gaps or repeats.
REQ-013 DONE SHALL assert dump_done for exactly 1 cycle, clear dump_busy, and return to IDLE.
REQ-014 dump_start SHALL be ignored in all states other than IDLE.
REQ-015 The counter SHALL never wrap; the terminal address is ram_depth-1, including non-power-of-2 depths.
REQ-016 The arbiter SHALL never assert a memory write while dump_busy=1, regardless of mips_Wr.

Reset
REQ-017 reset=0 SHALL asynchronously force state=IDLE, counter=0, dump_data=0, dump_addr=0, dump_valid=0, dump_busy=0, dump_done=0 and arb_err=0.
REQ-018 A reset asserted mid-dump SHALL abort the dump with no dump_done pulse, and the port SHALL return to MIPS passthrough immediately.

Configuration
REQ-019 Macro DATA_MEM_ARB_ERR_CHECK_EN, when defined, SHALL enable protocol checking:
- arb_err sets when ctrl_clk_mips=1 in READ or HOLD;
- arb_err sets when mips_Wr=1 in any non-IDLE state;
- arb_err stays set until reset.
REQ-020 Without DATA_MEM_ARB_ERR_CHECK_EN, arb_err SHALL be constant 0 and no checking logic SHALL be built.

Verification
REQ-021 Passthrough: IDLE, mips_Addr=5, mips_In_Data=0xDEADBEEF, mips_Wr=1 -> same cycle Addr=5, In_Data=0xDEADBEEF, Wr=1.
REQ-022 Full dump: memory word i = i+0x100, dump_ready tied 1, ctrl_clk_mips=0, dump_start pulse -> 64 words 0x100..0x13F at dump_addr 0..63, then a 1-cycle dump_done with dump_busy low after it.
REQ-023 Halt wait: ctrl_clk_mips=1 for 10 cycles after dump_start -> dump_busy=1, dump_valid=0 and no READ throughout, and the first word appears 2 cycles after ctrl_clk_mips falls.
REQ-024 Backpressure: dump_ready=0 for 7 cycles during word 3 -> dump_data and dump_addr=3 stable, with no skipped or duplicated addresses.
REQ-025 Reset mid-dump: reset=0 at word 20 -> all outputs 0 asynchronously, no dump_done, and after release Addr follows mips_Addr.
REQ-026 Error and write block (macro defined): mips_Wr=1 and ctrl_clk_mips=1 during HOLD -> Wr=0, arb_err=1 and held until reset; with the macro undefined -> arb_err=0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Purpose:
//   Sits between the MIPS MEM stage and the data memory. In normal operation it
//   passes the MIPS request straight through to the memory port. When the debug
//   unit asks for a dump, the arbiter raises a halt request, waits for the
//   pipeline to stop stepping, then streams every memory word (address 0 up to
//   ram_depth-1) to the debug unit with a valid/ready handshake. A one-cycle
//   done pulse marks the end of the dump.
//
// Optional feature:
//   `define DATA_MEM_ARB_ERR_CHECK_EN to build the sticky protocol checker that
//   drives arb_err. Without it arb_err is tied to 0 and no checker is built.
//
// Ports:
//   clk            in   single clock, all state changes on posedge
//   reset          in   asynchronous, active-low reset
//   ctrl_clk_mips  in   1 while the MIPS pipeline is advancing
//   mips_Addr      in   MEM-stage address                   [AW]
//   mips_In_Data   in   MEM-stage write data                [len_data]
//   mips_Wr        in   MEM-stage write strobe
//   mips_Rd        in   MEM-stage read strobe
//   dump_start     in   dump request pulse from the debug unit
//   dump_ready     in   debug unit can accept a word
//   mem_Data       in   combinational read data for Addr    [len_data]
//   Addr           out  muxed memory address                [AW]
//   In_Data        out  muxed memory write data             [len_data]
//   Wr             out  muxed memory write strobe
//   Rd             out  muxed memory read strobe
//   dump_data      out  dumped word                         [len_data]
//   dump_addr      out  address of dumped word              [AW]
//   dump_valid     out  dump_data/dump_addr are valid
//   dump_busy      out  dump in progress (MIPS halt request)
//   dump_done      out  one-cycle pulse at the end of a dump
//   arb_err        out  sticky protocol error flag
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
   parameter  int len_data  = 32,
   parameter  int ram_depth = 64,
   localparam int AW        = (ram_depth > 1) ? $clog2(ram_depth) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ctrl_clk_mips,
   input  logic [AW-1:0]       mips_Addr,
   input  logic [len_data-1:0] mips_In_Data,
   input  logic                mips_Wr,
   input  logic                mips_Rd,
   input  logic                dump_start,
   input  logic                dump_ready,
   input  logic [len_data-1:0] mem_Data,
   output logic [AW-1:0]       Addr,
   output logic [len_data-1:0] In_Data,
   output logic                Wr,
   output logic                Rd,
   output logic [len_data-1:0] dump_data,
   output logic [AW-1:0]       dump_addr,
   output logic                dump_valid,
   output logic                dump_busy,
   output logic                dump_done,
   output logic                arb_err
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_HALT,
      ST_READ,
      ST_HOLD,
      ST_DONE
   } state_t;

   // Terminal address is derived from the depth, not from AW, so that
   // non-power-of-2 depths stop at ram_depth-1 instead of wrapping.
   localparam logic [AW-1:0] LAST_ADDR = AW'(ram_depth - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [AW-1:0]         r_counter;
   logic [len_data-1:0]   r_dump_data;
   logic [AW-1:0]         r_dump_addr;
   logic                  r_dump_valid;
   logic                  r_dump_busy;
   logic                  r_dump_done;

   logic                  w_handshake;
   logic                  w_last;

   assign w_handshake = r_dump_valid & dump_ready;
   assign w_last      = (r_counter == LAST_ADDR);

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: the default assignment first guarantees a value on every path, so
   // no latch is inferred when a case arm leaves the signal untouched.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:      if (dump_start)     w_state_nxt = ST_WAIT_HALT;
         ST_WAIT_HALT: if (!ctrl_clk_mips) w_state_nxt = ST_READ;
         ST_READ:                          w_state_nxt = ST_HOLD;
         ST_HOLD:      if (w_handshake)    w_state_nxt = w_last ? ST_DONE : ST_READ;
         ST_DONE:                          w_state_nxt = ST_IDLE;
         default:                          w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Dump datapath: address counter, output word register, status flags
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_counter    <= '0;
         r_dump_data  <= '0;
         r_dump_addr  <= '0;
         r_dump_valid <= 1'b0;
         r_dump_busy  <= 1'b0;
         r_dump_done  <= 1'b0;
      end else begin
         r_dump_done <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (dump_start) begin
                  r_counter   <= '0;
                  r_dump_busy <= 1'b1;
               end
            end
            ST_READ: begin
               // mem_Data is the combinational read of Addr, which is the
               // counter in this state.
               r_dump_data  <= mem_Data;
               r_dump_addr  <= r_counter;
               r_dump_valid <= 1'b1;
            end
            ST_HOLD: begin
               if (w_handshake) begin
                  r_dump_valid <= 1'b0;
                  if (w_last) begin
                     r_dump_done <= 1'b1;
                  end else begin
                     r_counter <= r_counter + AW'(1);
                  end
               end
            end
            ST_DONE: begin
               r_dump_busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Memory port mux: passthrough only in IDLE; otherwise the dump owns the
   // port and writes are always blocked.
   // ---------------------------------------------------------------------------
   always_comb begin
      Addr    = r_counter;
      In_Data = '0;
      Wr      = 1'b0;
      Rd      = 1'b0;
      if (r_state == ST_IDLE) begin
         Addr    = mips_Addr;
         In_Data = mips_In_Data;
         Wr      = mips_Wr;
         Rd      = mips_Rd;
      end
   end

   assign dump_data  = r_dump_data;
   assign dump_addr  = r_dump_addr;
   assign dump_valid = r_dump_valid;
   assign dump_busy  = r_dump_busy;
   assign dump_done  = r_dump_done;

   // ---------------------------------------------------------------------------
   // Optional protocol checker
   // ---------------------------------------------------------------------------
`ifdef DATA_MEM_ARB_ERR_CHECK_EN
   logic r_arb_err;
   logic w_err_set;

   // The pipeline must stay halted while words are being read, and the MEM
   // stage must not try to write while the dump owns the port.
   assign w_err_set = (((r_state == ST_READ) || (r_state == ST_HOLD)) && ctrl_clk_mips)
                    || ((r_state != ST_IDLE) && mips_Wr);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_arb_err <= 1'b0;
      end else if (w_err_set) begin
         r_arb_err <= 1'b1;
      end
   end

   assign arb_err = r_arb_err;
`else
   assign arb_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Self-checking bench for data_mem_arbiter. A table of passthrough vectors is
// applied first, then dumps are run against a reference model that describes
// the dump stream in terms of "word k at address k, 2 cycles per word when
// ready, halt wait of N cycles", with randomized ready, MIPS traffic and
// spurious dump_start pulses. Hand-written sequences cover reset mid-dump and
// the write-block / error flag behaviour.
// Build with DATA_MEM_ARB_ERR_CHECK_EN defined to expect the checker active.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

   localparam int LEN     = 32;
   localparam int DEPTH   = 64;
   localparam int AW      = 6;
   localparam int MAX_CYC = 2000;
`ifdef DATA_MEM_ARB_ERR_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic            ctrl_clk_mips;
   logic [AW-1:0]   mips_Addr;
   logic [LEN-1:0]  mips_In_Data;
   logic            mips_Wr;
   logic            mips_Rd;
   logic            dump_start;
   logic            dump_ready;
   logic [LEN-1:0]  mem_Data;
   logic [AW-1:0]   Addr;
   logic [LEN-1:0]  In_Data;
   logic            Wr;
   logic            Rd;
   logic [LEN-1:0]  dump_data;
   logic [AW-1:0]   dump_addr;
   logic            dump_valid;
   logic            dump_busy;
   logic            dump_done;
   logic            arb_err;

   logic [LEN-1:0]  mem [DEPTH];

   int n_vec  = 0;
   int n_miss = 0;
   bit exp_err = 1'b0;

   always #5 clk = ~clk;

   // Behavioural memory: combinational read of whatever address is driven.
   assign mem_Data = mem[Addr];

   data_mem_arbiter #(.len_data(LEN), .ram_depth(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .ctrl_clk_mips(ctrl_clk_mips),
      .mips_Addr    (mips_Addr),
      .mips_In_Data (mips_In_Data),
      .mips_Wr      (mips_Wr),
      .mips_Rd      (mips_Rd),
      .dump_start   (dump_start),
      .dump_ready   (dump_ready),
      .mem_Data     (mem_Data),
      .Addr         (Addr),
      .In_Data      (In_Data),
      .Wr           (Wr),
      .Rd           (Rd),
      .dump_data    (dump_data),
      .dump_addr    (dump_addr),
      .dump_valid   (dump_valid),
      .dump_busy    (dump_busy),
      .dump_done    (dump_done),
      .arb_err      (arb_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_dump_data"},  dump_data,  '0);
      check({tag, "_dump_addr"},  dump_addr,  '0);
      check({tag, "_dump_valid"}, dump_valid, 0);
      check({tag, "_dump_busy"},  dump_busy,  0);
      check({tag, "_dump_done"},  dump_done,  0);
      check({tag, "_arb_err"},    arb_err,    0);
   endtask

   // ---------------------------------------------------------------------------
   // Passthrough vector table
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [AW-1:0]  addr;
      logic [LEN-1:0] data;
      logic           wr;
      logic           rd;
      logic [AW-1:0]  e_addr;
      logic [LEN-1:0] e_data;
      logic           e_wr;
      logic           e_rd;
   } pt_vec_t;

   pt_vec_t pt_tab [6];

   // ---------------------------------------------------------------------------
   // One complete dump against the reference model.
   //   halt       : cycles ctrl_clk_mips stays 1 after the request
   //   pct        : probability (%) dump_ready is 1 on a given cycle
   //   stall_word : word index held off for stall_len cycles (-1 for none)
   // ---------------------------------------------------------------------------
   task automatic dump_run(input int halt, input int pct, input int stall_word, input int stall_len);
      int            nhs;
      int            done_at;
      int            last_hs;
      int            next_v;
      int            stalled;
      int            n_dut_hs;
      bit            exp_busy;
      bit            exp_valid;
      bit            exp_done;
      bit            rdy;
      logic [AW-1:0] exp_cnt;

      nhs = 0; done_at = -1; last_hs = -1; next_v = halt + 3;
      stalled = 0; n_dut_hs = 0; exp_valid = 1'b0;

      @(negedge clk);
      dump_start    = 1'b1;
      ctrl_clk_mips = 1'b0;
      mips_Wr       = 1'b0;
      mips_Rd       = 1'b0;
      mips_Addr     = AW'($urandom);
      mips_In_Data  = $urandom;
      dump_ready    = 1'b0;
      #1;
      check("start_idle_addr", Addr, mips_Addr);
      check("start_idle_busy", dump_busy, 0);

      for (int c = 1; c <= MAX_CYC; c++) begin
         @(negedge clk);
         exp_busy = !(done_at >= 0 && c > done_at);
         if (c == next_v) exp_valid = 1'b1;
         exp_done = (nhs == DEPTH) && (c == last_hs + 1);
         if (exp_done) done_at = c;
         exp_cnt = (nhs >= DEPTH) ? AW'(DEPTH - 1) : AW'(nhs);

         dump_start    = exp_busy && ($urandom_range(7) == 0);
         ctrl_clk_mips = (c <= halt);
         mips_Addr     = AW'($urandom);
         mips_In_Data  = $urandom;
         mips_Rd       = 1'($urandom_range(1));
         mips_Wr       = 1'($urandom_range(1));
         if (exp_valid && nhs == stall_word && stalled < stall_len) begin
            rdy = 1'b0;
            stalled++;
         end else begin
            rdy = ($urandom_range(99) < pct);
         end
         dump_ready = rdy;
         #1;

         check("dump_busy",  dump_busy,  exp_busy);
         check("dump_valid", dump_valid, exp_valid);
         check("dump_done",  dump_done,  exp_done);
         check("arb_err",    arb_err,    exp_err);
         if (exp_busy) begin
            check("dump_port_addr", Addr,    exp_cnt);
            check("dump_port_wr",   Wr,      0);
            check("dump_port_rd",   Rd,      0);
            check("dump_port_data", In_Data, '0);
         end else begin
            check("post_pass_addr", Addr,    mips_Addr);
            check("post_pass_wr",   Wr,      mips_Wr);
            check("post_pass_rd",   Rd,      mips_Rd);
            check("post_pass_data", In_Data, mips_In_Data);
         end
         if (exp_valid) begin
            check("word_addr", dump_addr, nhs);
            check("word_data", dump_data, mem[nhs]);
         end

         if (dump_valid && dump_ready) n_dut_hs++;
         if (ERR_EN && exp_busy && mips_Wr) exp_err = 1'b1;
         if (exp_valid && rdy) begin
            nhs++;
            last_hs   = c;
            exp_valid = 1'b0;
            if (nhs < DEPTH) next_v = c + 2;
         end
         if (!exp_busy) break;
      end

      n_vec++;
      if (done_at < 0) begin
         n_miss++;
         $display("FAIL dump_timeout: dump not finished within %0d cycles", MAX_CYC);
      end
      check("dump_word_count", n_dut_hs, DEPTH);
      mips_Wr    = 1'b0;
      dump_start = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   initial begin
      bit found;

      reset = 1'b0; ctrl_clk_mips = 1'b0; mips_Addr = '0; mips_In_Data = '0;
      mips_Wr = 1'b0; mips_Rd = 1'b0; dump_start = 1'b0; dump_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] = LEN'(i + 32'h100);

      pt_tab[0] = '{6'd5,  32'hDEAD_BEEF, 1'b1, 1'b0, 6'd5,  32'hDEAD_BEEF, 1'b1, 1'b0};
      pt_tab[1] = '{6'd0,  32'h0000_0000, 1'b0, 1'b1, 6'd0,  32'h0000_0000, 1'b0, 1'b1};
      pt_tab[2] = '{6'd63, 32'hFFFF_FFFF, 1'b1, 1'b1, 6'd63, 32'hFFFF_FFFF, 1'b1, 1'b1};
      pt_tab[3] = '{6'd42, 32'h1234_5678, 1'b0, 1'b0, 6'd42, 32'h1234_5678, 1'b0, 1'b0};
      pt_tab[4] = '{6'd21, 32'hA5A5_5A5A, 1'b1, 1'b0, 6'd21, 32'hA5A5_5A5A, 1'b1, 1'b0};
      pt_tab[5] = '{6'd1,  32'h8000_0001, 1'b0, 1'b1, 6'd1,  32'h8000_0001, 1'b0, 1'b1};

      #1;
      check_outputs_zero("reset");
      check("reset_pass_addr", Addr, mips_Addr);

      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Passthrough table, applied in IDLE
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         mips_Addr    = pt_tab[i].addr;
         mips_In_Data = pt_tab[i].data;
         mips_Wr      = pt_tab[i].wr;
         mips_Rd      = pt_tab[i].rd;
         #1;
         check("pass_addr", Addr,    pt_tab[i].e_addr);
         check("pass_data", In_Data, pt_tab[i].e_data);
         check("pass_wr",   Wr,      pt_tab[i].e_wr);
         check("pass_rd",   Rd,      pt_tab[i].e_rd);
      end
      mips_Wr = 1'b0;

      // Full dump, ready tied high, no halt wait: words 0x100..0x13F
      dump_run(0, 100, -1, 0);
      // Halt wait of 10 cycles
      dump_run(10, 100, -1, 0);
      // Backpressure: word 3 held off for 7 cycles
      dump_run(0, 100, 3, 7);

      // Randomized dumps with random memory contents
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
         dump_run($urandom_range(5), $urandom_range(100, 30),
                  $urandom_range(DEPTH - 1), $urandom_range(6));
      end

      // Reset mid-dump at word 20
      for (int i = 0; i < DEPTH; i++) mem[i] = LEN'(i + 32'h100);
      @(negedge clk);
      dump_start = 1'b1; dump_ready = 1'b1; ctrl_clk_mips = 1'b0; mips_Wr = 1'b0;
      @(negedge clk);
      dump_start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (dump_valid && dump_addr == AW'(20)) begin
            found = 1'b1;
            break;
         end
      end
      check("rst_word20_reached", found, 1);
      #1;
      reset = 1'b0;
      exp_err = 1'b0;
      mips_Addr = 6'd37; mips_Wr = 1'b1;
      #1;
      check_outputs_zero("rst_mid");
      check("rst_mid_pass_addr", Addr, 6'd37);
      check("rst_mid_pass_wr",   Wr,   1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      mips_Wr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         mips_Addr = AW'($urandom);
         #1;
         check("rst_after_done", dump_done, 0);
         check("rst_after_busy", dump_busy, 0);
         check("rst_after_addr", Addr, mips_Addr);
      end

      // Write block and error flag while holding word 0
      @(negedge clk);
      dump_ready = 1'b0; dump_start = 1'b1;
      @(negedge clk);
      dump_start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (dump_valid) begin
            found = 1'b1;
            break;
         end
      end
      check("err_hold_reached", found, 1);
      mips_Wr = 1'b1; ctrl_clk_mips = 1'b1; mips_In_Data = 32'hCAFE_F00D;
      #1;
      check("err_wr_blocked",   Wr,      0);
      check("err_data_blocked", In_Data, '0);
      check("err_arb_err_pre",  arb_err, 0);
      @(negedge clk);
      mips_Wr = 1'b0; ctrl_clk_mips = 1'b0;
      #1;
      check("err_arb_err_set", arb_err, ERR_EN);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check("err_arb_err_sticky", arb_err, ERR_EN);
         check("err_hold_valid",     dump_valid, 1);
         check("err_hold_addr",      dump_addr,  0);
      end
      reset = 1'b0;
      #1;
      check("err_cleared_by_reset", arb_err, 0);
      @(negedge clk);
      reset = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
